instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 ADDR_W, 10, word-address width of the target instruction RAM; capacity 2^ADDR_W words.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-004 start  input  1  request to begin a load; honoured only in IDLE.
REQ-005 in_valid  input  1  byte-stream valid.
REQ-006 in_data  input  8  byte-stream data.
REQ-007 in_ready  output  1  byte-stream ready; a byte is accepted when in_valid && in_ready on a clock edge.
REQ-008 ram_load  output  1  high while a load is in progress; drives the core's fetch_ram_load so the pipeline is held off instruction RAM.
REQ-009 ram_we  output  1  instruction RAM write strobe, one cycle per word.
REQ-010 ram_addr  output  ADDR_W  instruction RAM word address.
REQ-011 ram_wdata  output  32  instruction word to write.
REQ-012 done  output  1  one-cycle pulse at end of load (success or error).
REQ-013 error  output  1  sticky error flag, cleared by reset or an accepted start.

Function
REQ-014 The FSM SHALL have states IDLE, LEN, DATA, CSUM, END.
REQ-015 IDLE -> LEN on start; start outside IDLE SHALL be ignored.
REQ-016 in_ready SHALL be high only in LEN, DATA, CSUM; gaps in in_valid SHALL stall assembly without loss.
REQ-017 Bytes SHALL assemble big-endian: first accepted byte of a word -> bits [31:24], fourth -> [7:0].
REQ-018 LEN SHALL accept 4 bytes forming word count N; N==0 -> END with no writes; N > 2^ADDR_W -> error=1, END, no writes; else -> DATA.
REQ-019 In DATA, ram_we SHALL be 1 for exactly the cycle after each word's 4th byte is accepted, with ram_wdata = that word and ram_addr = word index k (0..N-1); in_ready stays high (1 byte/cycle throughput).
REQ-020 After the Nth write, the FSM SHALL go to CSUM (macro defined) or END (macro undefined).
REQ-021 N == 2^ADDR_W SHALL be legal: last write at ram_addr all-ones; no address wrap write SHALL occur.
REQ-022 END SHALL last one cycle with done=1, then -> IDLE.
REQ-023 ram_load SHALL be 1 from the cycle after start is accepted through the END cycle inclusive, 0 otherwise.
REQ-024 ram_we SHALL never be 1 outside DATA or while ram_load is 0.

Reset
REQ-025 On reset: state=IDLE, in_ready=0, ram_load=0, ram_we=0, ram_addr=0, ram_wdata=0, done=0, error=0, byte/word counters and checksum=0.
REQ-026 Reset mid-load SHALL abort immediately: no further writes, no done pulse; words already written remain in RAM.

Configuration
REQ-027 Macro LOADER_CHECKSUM_EN, defined: after N words, CSUM accepts 4 bytes (big-endian) and compares with the mod-2^32 sum of all data words; mismatch sets error=1; done pulses in END either way.
REQ-028 LOADER_CHECKSUM_EN undefined: no CSUM state reached, no trailer bytes consumed, error set only by oversize N.

Verification
REQ-029 start; bytes 00 00 00 02, 20 08 00 05, 21 09 00 07 -> ram_we at addr 0 data 0x20080005, addr 1 data 0x21090007, done one cycle, ram_load falls next cycle, error=0 (macro undefined).
REQ-030 Macro defined, same stream plus trailer 41 11 00 0C -> done, error=0; trailer 41 11 00 0D -> done, error=1, both words still written.
REQ-031 ADDR_W=2, N=5 -> no ram_we, error=1, done; N=4 -> writes at addr 0..3, no fifth write.
REQ-032 N=0 -> no ram_we, done one cycle after 4th length byte, error=0.
REQ-033 in_valid toggling every other cycle during DATA -> identical write data/addresses as back-to-back stream; start pulsed mid-load ignored.
REQ-034 reset asserted after first word written -> ram_load=0, no further ram_we, no done; subsequent full load succeeds.

Source files
------------

// File: rtl/instr_loader.sv
// Instruction RAM loader: turns a byte stream (length word, N data words, optional checksum word)
// into word writes to the core's instruction RAM, holding fetch off the RAM while loading.
// Optional feature: define LOADER_CHECKSUM_EN to require and verify a trailing checksum word.
module instr_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              ram_load,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {StIdle, StLen, StData, StCsum, StEnd} state_e;

  // Largest legal word count; one wider than the address so 2^ADDR_W itself is representable.
  localparam logic [32:0] Capacity = 33'd1 << ADDR_W;

  state_e            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [31:0]       csum_q, csum_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic              error_q, error_d;

  logic              accept;
  logic              byte_last;
  logic              words_done;
  logic [31:0]       word;

  assign accept     = in_valid && in_ready;
  assign byte_last  = (byte_cnt_q == 2'd3);
  assign words_done = (word_cnt_q == len_q);
  // Current byte completes the big-endian word held so far.
  assign word       = {shift_q, in_data};

  assign ram_load  = (state_q != StIdle);
  assign done      = (state_q == StEnd);
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign error     = error_q;

  // Byte acceptance window; closed during the final write so the next field waits for it.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      StLen:   in_ready = 1'b1;
      StData:  in_ready = !words_done;
      StCsum:  in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // Next-state: byte assembly, length decode, word writes and checksum compare.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    csum_d      = csum_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    error_d     = error_q;

    if (accept) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      shift_d    = word[23:0];
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StLen;
          byte_cnt_d = '0;
          shift_d    = '0;
          word_cnt_d = '0;
          csum_d     = '0;
          error_d    = 1'b0;
        end
      end
      StLen: begin
        if (accept && byte_last) begin
          if (word == 32'd0) begin
            state_d = StEnd;
          end else if ({1'b0, word} > Capacity) begin
            error_d = 1'b1;
            state_d = StEnd;
          end else begin
            len_d   = word[ADDR_W:0];
            state_d = StData;
          end
        end
      end
      StData: begin
        if (words_done) begin
          // The last word's write strobe is out this cycle.
`ifdef LOADER_CHECKSUM_EN
          state_d = StCsum;
`else
          state_d = StEnd;
`endif
        end else if (accept && byte_last) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = word_cnt_q[ADDR_W-1:0];
          ram_wdata_d = word;
          word_cnt_d  = word_cnt_q + 1'b1;
          csum_d      = csum_q + word;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCsum: begin
        if (accept && byte_last) begin
          if (word != csum_q) begin
            error_d = 1'b1;
          end
          state_d = StEnd;
        end
      end
`endif
      StEnd:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      len_q       <= '0;
      word_cnt_q  <= '0;
      csum_q      <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      csum_q      <= csum_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader (ADDR_W=2, capacity 4 words): expected writes and done
// events are queued when a load is issued; a negedge monitor pops and compares them.
module tb_instr_loader;

  localparam int unsigned AW = 2;
  localparam int unsigned Cap = 1 << AW;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          ram_load;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic          done;
  logic          error;

  typedef struct {
    bit          is_done;
    logic [AW-1:0] addr;
    logic [31:0] data;
    bit          err;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          prev_done = 1'b0;
  logic [31:0] words[0:7];

  instr_loader #(.ADDR_W(AW)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .ram_load (ram_load),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .done     (done),
    .error    (error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // Monitor: every write strobe and done pulse must match the head of the expected queue.
  always @(negedge clock) begin
    ev_t e;
    if (prev_done) begin
      chk("ram_load_falls_after_done", ram_load, 0);
      chk("done_one_cycle", done, 0);
    end
    prev_done = (done === 1'b1);
    if (ram_we === 1'b1) begin
      chk("we_only_under_load", ram_load, 1);
      if (exp_q.size() == 0 || exp_q[0].is_done) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %h, no write required", ram_addr, ram_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", ram_addr, e.addr);
        chk("write_data", ram_wdata, e.data);
      end
    end
    if (done === 1'b1) begin
      if (exp_q.size() == 0 || !exp_q[0].is_done) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done, required %0d more writes first", exp_q.size());
      end else begin
        e = exp_q.pop_front();
        chk("done_error", error, e.err);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    repeat (gap) @(negedge clock);
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready=%b, required 1", in_ready);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8], gap);
    end
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clock);
      t++;
    end
    chk(name, exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge clock);
  endtask

  // Model: legal N writes words[0..N-1] at addresses 0..N-1; oversize N flags error with no
  // writes; the checksum trailer (when enabled) is the 32-bit wrapped sum of the data words.
  task automatic run_load(input logic [31:0] n, input int gap, input bit bad_csum,
                          input bit mid_start);
    logic [31:0] sum;
    logic [31:0] trailer;
    bit          legal;
    bit          err;
    int          cnt;
    ev_t         e;
    sum     = 32'd0;
    legal   = (n != 32'd0) && (n <= 32'(Cap));
    err     = (n > 32'(Cap));
    cnt     = legal ? int'(n) : 0;
    for (int k = 0; k < cnt; k++) begin
      e = '{is_done: 1'b0, addr: AW'(k), data: words[k], err: 1'b0};
      exp_q.push_back(e);
      sum = sum + words[k];
    end
    trailer = bad_csum ? sum + 32'd1 : sum;
`ifdef LOADER_CHECKSUM_EN
    if (legal && bad_csum) err = 1'b1;
`endif
    e = '{is_done: 1'b1, addr: '0, data: '0, err: err};
    exp_q.push_back(e);

    pulse_start();
    @(negedge clock);
    chk("error_cleared_by_start", error, 0);
    chk("ram_load_after_start", ram_load, 1);
    send_word(n, gap);
    if (!legal) begin
      @(negedge clock);
      chk("done_right_after_length", done, 1);
    end
    for (int k = 0; k < cnt; k++) begin
      send_word(words[k], gap);
      if (mid_start && k == 0) pulse_start();
    end
`ifdef LOADER_CHECKSUM_EN
    if (legal) send_word(trailer, gap);
`else
    if (legal && trailer == 32'hFFFF_FFFF) $display("note: all-ones sum, no trailer sent");
`endif
    drain("load_events_seen");
    chk("error_sticky_after_done", error, err);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ram_load", ram_load, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);

    // Two-word reference stream, then the same stream stalled with a mid-load start pulse.
    words[0] = 32'h2008_0005;
    words[1] = 32'h2109_0007;
    run_load(32'd2, 0, 1'b0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    run_load(32'd2, 0, 1'b1, 1'b0);
`endif
    run_load(32'd2, 1, 1'b0, 1'b1);

    // Capacity boundaries: one past capacity, exactly capacity, far oversize, and empty.
    words[2] = 32'hDEAD_BEEF;
    words[3] = 32'hFFFF_FFF0;
    run_load(32'd5, 0, 1'b0, 1'b0);
    run_load(32'd4, 0, 1'b0, 1'b0);
    run_load(32'h8000_0004, 0, 1'b0, 1'b0);
    run_load(32'd0, 0, 1'b0, 1'b0);

    // Reset after the first word is written: abort with no further writes and no done.
    words[0] = 32'h1234_5678;
    words[1] = 32'h9ABC_DEF0;
    exp_q.push_back('{is_done: 1'b0, addr: '0, data: words[0], err: 1'b0});
    pulse_start();
    send_word(32'd3, 0);
    send_word(words[0], 0);
    send_byte(words[1][31:24], 0);
    send_byte(words[1][23:16], 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("abort_ram_load", ram_load, 0);
    chk("abort_ram_we", ram_we, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_done", done, 0);
    repeat (6) @(negedge clock);
    chk("abort_first_write_only", exp_q.size(), 0);
    exp_q.delete();
    run_load(32'd2, 0, 1'b0, 1'b0);

    // Randomized loads, including stalls, bad trailers and huge lengths.
    for (int it = 0; it < 24; it++) begin
      logic [31:0] n;
      n = 32'($urandom_range(0, 6));
      if ($urandom_range(0, 5) == 0) n = $urandom | 32'h8000_0000;
      for (int k = 0; k < 8; k++) words[k] = $urandom;
      run_load(n, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
